color_mask_filter: RTL and testbench
====================================

Name: color_mask_filter

Overview:
- Upstream stage of the centroid calculator.
- Converts the incoming 24-bit RGB video stream into the binary mask pixel the centroid stage consumes: 8'hFF for a target pixel, 8'h00 otherwise.
- Applies a per-channel colour window, then a horizontal run-length noise filter.
- Outputs pixel, hcount and vcount delayed together so they stay aligned.
- Reports the per-frame count of mask pixels for debug display and for auto-tuning of the thresholds.

Parameters:
- MIN_RUN, 3, minimum consecutive in-window pixels on a line before output goes white (legal 1..15)
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame

Ports:
- clk  input  1  pixel clock
- reset_n  input  1  synchronous, active-low reset
- hcount_in  input  11  horizontal position of rgb_in
- vcount_in  input  10  vertical position of rgb_in
- rgb_in  input  24  pixel {R[23:16],G[15:8],B[7:0]}
- thresh_lo  input  24  per-channel lower bound {R,G,B}, inclusive
- thresh_hi  input  24  per-channel upper bound {R,G,B}, inclusive
- pixel_out  output  8  8'hFF = mask pixel, 8'h00 otherwise
- hcount_out  output  11  hcount_in delayed 2 cycles
- vcount_out  output  10  vcount_in delayed 2 cycles
- frame_white_count  output  20  mask pixels in the last complete frame
- frame_done  output  1  one-cycle pulse when frame_white_count updates

Behaviour:
- Reset (reset_n low at a clk edge): all outputs go to 0. Pipeline registers and run counter are cleared. Shadow thresholds go to lo=24'hFFFFFF, hi=24'h000000, so no pixel matches until the first frame start.
- Reset mid-frame: the statistics for that frame are discarded and no frame_done fires for it.
- Threshold shadowing:
  - thresh_lo/thresh_hi are copied into shadow registers only on the cycle hcount_in==0 && vcount_in==0.
  - That pixel and all later pixels of the frame use the new values.
  - Changes to thresh_lo/thresh_hi mid-frame have no effect until the next frame start.
- Stage 1 (cycle N+1):
  - Register hcount and vcount.
  - match = (lo.R<=R<=hi.R) && (lo.G<=G<=hi.G) && (lo.B<=B<=hi.B), all unsigned compares.
  - A channel with lo > hi never matches.
  - active = hcount_in<H_ACTIVE && vcount_in<V_ACTIVE; match is forced to 0 when not active.
- Stage 2 (cycle N+2), run filter:
  - 4-bit run counter, saturating at MIN_RUN.
  - If the stage-1 hcount==0, the counter loads match?1:0 (no carry across lines).
  - Otherwise the counter is cleared when match=0 and incremented (saturating) when match=1.
  - pixel_out = 8'hFF iff the next counter value >= MIN_RUN.
  - Consequence: the first MIN_RUN-1 pixels of every run are dropped. Runs shorter than MIN_RUN produce no white output. MIN_RUN=1 gives a pure threshold.
- Latency: exactly 2 clk cycles from input to pixel_out/hcount_out/vcount_out, for every pixel including blanking. The outputs are always mutually aligned.
- Frame statistics:
  - A 20-bit accumulator clears on the cycle the output coordinates are (0,0); that pixel is then counted if white.
  - The accumulator increments for each output pixel ==8'hFF.
  - On the cycle the output coordinates are (H_ACTIVE-1, V_ACTIVE-1), frame_white_count is loaded with the final total including that pixel, and frame_done pulses high for one cycle on the following cycle.
  - The maximum count is 786432, which fits in 20 bits, so no saturation is needed.
  - If (0,0) is never reached after reset, frame_done never fires.
- No backpressure; one pixel is accepted every clk.

Test Plan:
- Reset then frame of all rgb=24'h00FF00 with lo=24'h00C000, hi=24'h40FF40, MIN_RUN=3 -> columns 0,1 of each active line 8'h00, columns 2..1023 8'hFF; frame_white_count=1022*768=784896; frame_done a single pulse 1 cycle after output (1023,767).
- Same thresholds, line with green runs of length 2 at x=100 and length 5 at x=200 -> no white near x=100; white exactly at x=202..204 at the output (hcount_out=202..204, vcount_out unchanged).
- Change thresh_hi to 24'h000000 at (500,300) mid-frame -> rest of frame unaffected (still white); next frame all 8'h00, frame_white_count=0.
- Run continuing from x=1023 into blanking and the next line start at x=0 -> counter restarts at line start; x=0,1 of the new line are not white even though the previous line ended in a run.
- Assert reset_n low for one cycle at (10,10) mid-frame -> all outputs 0 the next cycle; no frame_done at the end of that frame; shadows no-match until the next (0,0).
- Constant input stream with hcount_in incrementing -> hcount_out/vcount_out equal the inputs delayed exactly 2 cycles, including blanking (hcount up to 1343).

Source files
------------

// File: rtl/color_mask_filter.sv
// color_mask_filter: turns an RGB stream into a binary mask (8'hFF / 8'h00)
// using a per-channel colour window followed by a horizontal run-length filter.
// Also counts the mask pixels of each frame. Latency is 2 clk for pixel and
// coordinates alike.
module color_mask_filter #(
    parameter int MIN_RUN  = 3,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [23:0] rgb_in,
    input  logic [23:0] thresh_lo,
    input  logic [23:0] thresh_hi,
    output logic [7:0]  pixel_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [19:0] frame_white_count,
    output logic        frame_done
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [3:0]  MIN_C  = 4'(MIN_RUN);

    logic [23:0] lo_q, lo_d, hi_q, hi_d;
    logic [10:0] h1_q, h1_d, h2_q, h2_d;
    logic [9:0]  v1_q, v1_d, v2_q, v2_d;
    logic        match1_q, match1_d;
    logic        vld1_q, vld1_d, vld2_q, vld2_d;
    logic [3:0]  run_q, run_d;
    logic [7:0]  pixel_q, pixel_d;
    logic [19:0] acc_q, acc_d;
    logic        seen_q, seen_d;
    logic [19:0] fwc_q, fwc_d;
    logic        done_q, done_d;

    logic frame_start, active, white2, out_start, out_last;

    // Stage 1: threshold shadowing (new values apply from the (0,0) pixel itself) and window match
    always_comb begin
        frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
        lo_d        = frame_start ? thresh_lo : lo_q;
        hi_d        = frame_start ? thresh_hi : hi_q;
        active      = (hcount_in < H_ACT) && (vcount_in < V_ACT);
        match1_d    = active;
        for (int c = 0; c < 3; c++) begin
            if ((rgb_in[c*8 +: 8] < lo_d[c*8 +: 8]) || (rgb_in[c*8 +: 8] > hi_d[c*8 +: 8]))
                match1_d = 1'b0;
        end
        h1_d   = hcount_in;
        v1_d   = vcount_in;
        vld1_d = 1'b1;
    end

    // Stage 2: run-length filter, counter restarts at every line start
    always_comb begin
        if (h1_q == 11'd0)
            run_d = {3'b000, match1_q};
        else if (!match1_q)
            run_d = 4'd0;
        else if (run_q >= MIN_C)
            run_d = MIN_C;
        else
            run_d = run_q + 4'd1;
        pixel_d = (run_d >= MIN_C) ? 8'hFF : 8'h00;
        h2_d    = h1_q;
        v2_d    = v1_q;
        vld2_d  = vld1_q;
    end

    // Frame statistics on the output side; vld2 keeps post-reset zero coordinates from starting a frame
    always_comb begin
        white2    = vld2_q && (pixel_q == 8'hFF);
        out_start = vld2_q && (h2_q == 11'd0) && (v2_q == 10'd0);
        out_last  = vld2_q && (h2_q == H_LAST) && (v2_q == V_LAST);
        acc_d     = out_start ? {19'd0, white2} : acc_q + {19'd0, white2};
        seen_d    = seen_q | out_start;
        done_d    = out_last && seen_d;
        fwc_d     = done_d ? acc_d : fwc_q;
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lo_q     <= 24'hFFFFFF;
            hi_q     <= 24'h000000;
            h1_q     <= '0;
            v1_q     <= '0;
            match1_q <= 1'b0;
            vld1_q   <= 1'b0;
            h2_q     <= '0;
            v2_q     <= '0;
            vld2_q   <= 1'b0;
            run_q    <= '0;
            pixel_q  <= '0;
            acc_q    <= '0;
            seen_q   <= 1'b0;
            fwc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            h1_q     <= h1_d;
            v1_q     <= v1_d;
            match1_q <= match1_d;
            vld1_q   <= vld1_d;
            h2_q     <= h2_d;
            v2_q     <= v2_d;
            vld2_q   <= vld2_d;
            run_q    <= run_d;
            pixel_q  <= pixel_d;
            acc_q    <= acc_d;
            seen_q   <= seen_d;
            fwc_q    <= fwc_d;
            done_q   <= done_d;
        end
    end

    assign pixel_out         = pixel_q;
    assign hcount_out        = h2_q;
    assign vcount_out        = v2_q;
    assign frame_white_count = fwc_q;
    assign frame_done        = done_q;

endmodule

// File: tb/tb_color_mask_filter.sv
// Scoreboard bench for color_mask_filter on a reduced 32x8 raster (40x10 with blanking).
module tb_color_mask_filter;

    localparam int MIN_RUN = 3;
    localparam int H_ACT   = 32;
    localparam int V_ACT   = 8;
    localparam int H_TOT   = 40;
    localparam int V_TOT   = 10;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] LO    = 24'h00C000;
    localparam logic [23:0] HI    = 24'h40FF40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [23:0] rgb_in, thresh_lo, thresh_hi;
    logic [7:0]  pixel_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [19:0] frame_white_count;
    logic        frame_done;

    color_mask_filter #(.MIN_RUN(MIN_RUN), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
        .clk(clk), .reset_n(reset_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .rgb_in(rgb_in), .thresh_lo(thresh_lo), .thresh_hi(thresh_hi),
        .pixel_out(pixel_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .frame_white_count(frame_white_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  px;
        logic [10:0] h;
        logic [9:0]  v;
        logic        done;
        logic [19:0] cnt;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_bad = 0;
    int done_seen = 0;
    logic [19:0] last_fwc = '0;

    // reference model state
    logic [23:0] m_lo, m_hi;
    int m_run;
    int m_acc;
    bit m_seen, m_pend;
    logic [19:0] m_fwc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        m_lo = 24'hFFFFFF; m_hi = 24'h000000;
        m_run = 0; m_acc = 0; m_seen = 0; m_pend = 0; m_fwc = '0;
        z.px = '0; z.h = '0; z.v = '0; z.done = 1'b0; z.cnt = '0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic model_pixel(input int h, input int v, input logic [23:0] rgb,
                               input logic [23:0] tlo, input logic [23:0] thi);
        exp_t e;
        bit match, w;
        if (h == 0 && v == 0) begin m_lo = tlo; m_hi = thi; end
        match = (h < H_ACT) && (v < V_ACT);
        for (int c = 0; c < 3; c++)
            if (rgb[c*8 +: 8] < m_lo[c*8 +: 8] || rgb[c*8 +: 8] > m_hi[c*8 +: 8]) match = 0;
        if (h == 0) m_run = match ? 1 : 0;
        else if (!match) m_run = 0;
        else if (m_run < MIN_RUN) m_run = m_run + 1;
        w = (m_run >= MIN_RUN);
        e.px = w ? 8'hFF : 8'h00;
        e.h = 11'(h); e.v = 10'(v);
        e.done = m_pend; e.cnt = m_fwc;
        m_pend = 0;
        if (h == 0 && v == 0) begin m_acc = int'(w); m_seen = 1; end
        else m_acc = m_acc + int'(w);
        if (h == H_ACT-1 && v == V_ACT-1 && m_seen) begin m_pend = 1; m_fwc = 20'(m_acc); end
        q.push_back(e);
    endtask

    // one pixel per clock: compare the output due now, then drive the next input
    task automatic step(input int h, input int v, input logic [23:0] rgb, input bit rst);
        exp_t o;
        @(negedge clk);
        if (q.size() >= 2) begin
            o = q.pop_front();
            check("pixel", 32'(pixel_out), 32'(o.px));
            check("hcount", 32'(hcount_out), 32'(o.h));
            check("vcount", 32'(vcount_out), 32'(o.v));
            check("done", 32'(frame_done), 32'(o.done));
            check("fwc", 32'(frame_white_count), 32'(o.cnt));
        end
        if (frame_done === 1'b1) begin done_seen++; last_fwc = frame_white_count; end
        hcount_in = 11'(h); vcount_in = 10'(v); rgb_in = rgb; reset_n = !rst;
        if (rst) model_reset();
        else model_pixel(h, v, rgb, thresh_lo, thresh_hi);
    endtask

    function automatic logic [23:0] pix_rgb(input int kind, input int h, input int v);
        if (kind == 1) begin
            if (v < 2) return 24'h000000;
            if (v == 2) return ((h == 10 || h == 11) || (h >= 20 && h <= 24)) ? GREEN : 24'h000000;
        end
        return GREEN;
    endfunction

    task automatic frame(input int kind);
        for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++) begin
                if (kind == 1 && h == 5 && v == 4) thresh_hi = 24'h000000;
                step(h, v, pix_rgb(kind, h, v), (kind == 3 && h == 10 && v == 3));
            end
    endtask

    initial begin
        reset_n = 1'b0; hcount_in = '0; vcount_in = '0; rgb_in = '0;
        thresh_lo = LO; thresh_hi = HI;
        for (int i = 0; i < 3; i++) step(H_TOT-1, V_TOT-1, 24'h0, 1'b1);

        frame(0);   // full green frame
        check("frameA_done_cnt", 32'(done_seen), 32'd1);
        check("frameA_total", 32'(last_fwc), 32'(30*8));

        frame(1);   // short/long runs on line 2, threshold killed mid-frame
        check("frameB_done_cnt", 32'(done_seen), 32'd2);
        check("frameB_total", 32'(last_fwc), 32'(3 + 5*30));

        frame(2);   // hi=0 taken at frame start: nothing matches
        check("frameC_done_cnt", 32'(done_seen), 32'd3);
        check("frameC_total", 32'(last_fwc), 32'd0);

        thresh_hi = HI;
        frame(3);   // reset pulse mid-frame: no frame_done for it
        check("frameD_done_cnt", 32'(done_seen), 32'd3);

        frame(0);
        check("frameE_done_cnt", 32'(done_seen), 32'd4);
        check("frameE_total", 32'(last_fwc), 32'(30*8));

        for (int h = 0; h < 1344; h++) step(h, V_TOT-1, GREEN, 1'b0);
        step(0, V_TOT-1, GREEN, 1'b0);
        step(1, V_TOT-1, GREEN, 1'b0);
        step(2, V_TOT-1, GREEN, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
